pbit_rng_arbiter: RTL and testbench

PBIT_RNG_ARBITER -- requirements
Module: pbit_rng_arbiter

---
 rtl/pbit_pkg.sv | 20 ++
 rtl/lfsr_core.sv | 30 +++
 rtl/pbit_rng_arbiter.sv | 143 ++++++++++++++
 tb/tb_pbit_rng_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pbit_pkg.sv
// rtl/pbit_pkg.sv - shared FSM encoding and LFSR constants for the p-bit RNG arbiter
package pbit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_RESEED = 2'd2
    } arb_state_e;

    // Feedback taps: bits 31, 21, 1 and 0
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    // XNOR feedback can never leave the all-ones state
    localparam logic [31:0] LFSR_LOCKUP = 32'hFFFF_FFFF;

    // One LFSR step: shift left, XNOR of the tapped bits enters at bit 0
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ~^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - 32-bit XNOR LFSR with synchronous load and step enable
module lfsr_core
    import pbit_pkg::*;
#(
    parameter logic [31:0] SEED = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] state
);

    logic [31:0] state_q;

    // Reset to SEED; a load beats a step; otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else if (load) begin
            state_q <= load_val;
        end else if (en) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/pbit_rng_arbiter.sv
// rtl/pbit_rng_arbiter.sv - round-robin arbiter sharing one LFSR among p-bit requesters
module pbit_rng_arbiter
    import pbit_pkg::*;
#(
    parameter int          NREQ  = 4,
    parameter int          WIDTH = 32,
    parameter logic [31:0] SEED  = 32'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] rnd,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    output logic             busy,
    output logic [15:0]      sweep_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    arb_state_e       state_q;
    logic [IW-1:0]    ptr_q;
    logic [NREQ-1:0]  gnt_q;
    logic [WIDTH-1:0] rnd_q;
    logic             busy_q;
    logic [15:0]      sweep_cnt_q;
    logic             reseed_pend_q;
    logic [31:0]      seed_hold_q;

    logic             reseed_go;
    logic             grant_go;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    ptr_d;
    logic [NREQ-1:0]  win_onehot;
    int               cand;
    logic [IW-1:0]    cand_idx;
    logic [31:0]      seed_sel;
    logic [31:0]      load_val;
    logic [31:0]      lfsr_state;

    // A reseed strobe that lands while busy is remembered and served from IDLE;
    // reseed has priority over requests, which simply stay pending
    assign reseed_go = (state_q == ST_IDLE) && (seed_load || reseed_pend_q);
    assign grant_go  = (state_q == ST_IDLE) && !reseed_go && win_found;

    // Round-robin search starting at ptr, wrapping modulo NREQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    assign ptr_d      = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

    // A fresh strobe supplies its own seed; a deferred one uses the held copy.
    // The all-ones lock-up value is replaced by SEED.
    assign seed_sel = seed_load ? seed : seed_hold_q;
    assign load_val = (seed_sel == LFSR_LOCKUP) ? SEED : seed_sel;

    lfsr_core #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (grant_go),
        .load     (reseed_go),
        .load_val (load_val),
        .state    (lfsr_state)
    );

    // Control FSM: IDLE issues a grant or a reseed, each lasting exactly one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            gnt_q         <= '0;
            rnd_q         <= '0;
            busy_q        <= 1'b0;
            sweep_cnt_q   <= '0;
            reseed_pend_q <= 1'b0;
            seed_hold_q   <= '0;
        end else begin
            if (seed_load) begin
                seed_hold_q <= seed;
            end
            case (state_q)
                ST_IDLE: begin
                    if (reseed_go) begin
                        state_q       <= ST_RESEED;
                        busy_q        <= 1'b1;
                        reseed_pend_q <= 1'b0;
                    end else if (grant_go) begin
                        state_q <= ST_GRANT;
                        busy_q  <= 1'b1;
                        gnt_q   <= win_onehot;
                        rnd_q   <= WIDTH'(lfsr_state);
                        ptr_q   <= ptr_d;
                        if (win_idx == LAST_IDX) begin
                            sweep_cnt_q <= sweep_cnt_q + 16'd1;
                        end
                    end
                end
                ST_GRANT, ST_RESEED: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    gnt_q   <= '0;
                    rnd_q   <= '0;
                    if (seed_load) begin
                        reseed_pend_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    gnt_q   <= '0;
                    rnd_q   <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rnd       = rnd_q;
    assign busy      = busy_q;
    assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_pbit_rng_arbiter.sv
// tb/tb_pbit_rng_arbiter.sv - scoreboard bench for pbit_rng_arbiter
module tb_pbit_rng_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [31:0] rnd;
    logic        seed_load;
    logic [31:0] seed;
    logic        busy;
    logic [15:0] sweep_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected grants: {gnt[3:0], rnd[31:0]}
    logic [35:0] sb[$];

    pbit_rng_arbiter #(
        .NREQ  (4),
        .WIDTH (32),
        .SEED  (32'd1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .rnd       (rnd),
        .seed_load (seed_load),
        .seed      (seed),
        .busy      (busy),
        .sweep_cnt (sweep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [31:0] r);
        sb.push_back({g, r});
    endtask

    // Monitor: every presented grant is popped against the scoreboard
    always @(negedge clk) begin
        logic [35:0] e;
        if (gnt !== 4'b0000) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: got gnt=%b rnd=%h, expected no grant", gnt, rnd);
            end else begin
                e = sb.pop_front();
                chk("grant_gnt", {28'b0, gnt}, {28'b0, e[35:32]});
                chk("grant_rnd", rnd, e[31:0]);
            end
        end else begin
            chk("idle_rnd_zero", rnd, 32'h0);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        seed_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_gnt", {28'b0, gnt}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_sweep", {16'b0, sweep_cnt}, 32'h0);
    endtask

    // Requesters hold req until they see gnt, then drop it the following cycle
    task automatic run_reqs(input logic [3:0] mask);
        logic [3:0] pending;
        logic [3:0] drop;
        int cyc;
        pending = mask;
        drop = '0;
        req = mask;
        cyc = 0;
        while ((pending != 0 || drop != 0) && cyc < 40) begin
            @(posedge clk);
            #1;
            req = req & ~drop;
            drop = gnt & pending;
            pending = pending & ~gnt;
            cyc++;
        end
        req = '0;
        chk("req_served_in_time", {28'b0, pending}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        seed_load = 1'b0;
        seed = '0;

        // Single request: latency of one cycle, rnd = SEED, LFSR steps to 2
        do_reset();
        push(4'b0001, 32'h0000_0001);
        req = 4'b0001;
        @(posedge clk); #1;
        req = 4'b0000;
        chk("latency_gnt", {28'b0, gnt}, 32'h1);
        chk("grant_busy", {31'b0, busy}, 32'h1);
        chk("lfsr_after_first", dut.u_lfsr.state, 32'h0000_0002);
        @(posedge clk); #1;
        chk("idle_busy", {31'b0, busy}, 32'h0);
        // req held past its grant counts as a fresh request
        push(4'b0001, 32'h0000_0002);
        push(4'b0001, 32'h0000_0004);
        req = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        req = 4'b0000;
        @(posedge clk); #1;

        // Full sweep: order 0,1,2,3 with successive LFSR words
        do_reset();
        push(4'b0001, 32'h0000_0001);
        push(4'b0010, 32'h0000_0002);
        push(4'b0100, 32'h0000_0004);
        push(4'b1000, 32'h0000_0009);
        run_reqs(4'b1111);
        chk("sweep_after_one", {16'b0, sweep_cnt}, 32'h1);

        // Pointer at 0: 0 then 2; pointer at 3 wraps: 0 then 1
        push(4'b0001, 32'h0000_0012);
        push(4'b0100, 32'h0000_0024);
        run_reqs(4'b0101);
        push(4'b0001, 32'h0000_0049);
        push(4'b0010, 32'h0000_0092);
        run_reqs(4'b0011);
        chk("sweep_unchanged", {16'b0, sweep_cnt}, 32'h1);

        // Reseed beats a same-cycle request
        seed_load = 1'b1;
        seed = 32'h1234_5678;
        req = 4'b0010;
        @(posedge clk); #1;
        seed_load = 1'b0;
        chk("reseed_busy", {31'b0, busy}, 32'h1);
        chk("reseed_no_gnt", {28'b0, gnt}, 32'h0);
        push(4'b0010, 32'h1234_5678);
        run_reqs(4'b0010);

        // All-ones seed falls back to SEED
        seed_load = 1'b1;
        seed = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        seed_load = 1'b0;
        push(4'b0001, 32'h0000_0001);
        run_reqs(4'b0001);

        // Reset during GRANT
        do_reset();
        push(4'b1000, 32'h0000_0001);
        req = 4'b1000;
        @(posedge clk); #1;
        chk("pre_reset_gnt", {28'b0, gnt}, 32'h8);
        chk("pre_reset_sweep", {16'b0, sweep_cnt}, 32'h1);
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midgrant_gnt", {28'b0, gnt}, 32'h0);
        chk("midgrant_busy", {31'b0, busy}, 32'h0);
        chk("midgrant_sweep", {16'b0, sweep_cnt}, 32'h0);
        chk("midgrant_lfsr", dut.u_lfsr.state, 32'h0000_0001);

        // Sweep counter wrap
        do_reset();
        force dut.sweep_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.sweep_cnt_q;
        @(posedge clk); #1;
        chk("sweep_preset", {16'b0, sweep_cnt}, 32'h0000_FFFF);
        push(4'b1000, 32'h0000_0001);
        run_reqs(4'b1000);
        chk("sweep_wrap", {16'b0, sweep_cnt}, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
